// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions, machine interrupts and mret, drains the pipeline, commits to CSRs, redirects fetch.
// Latency: request seen in IDLE -> IDLE again after 4 cycles minimum (FLUSH, COMMIT, REDIRECT, back to IDLE).
// Backpressure: waits in FLUSH for flush_done and in REDIRECT for redirect_ready; requests outside IDLE are ignored.
module trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            exc_req,
  input  logic [4:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            mret_req,
  input  logic [XLEN-1:0] irq_lines,
  input  logic [XLEN-1:0] next_pc,
  output logic            flush,
  input  logic            flush_done,
  output logic            trap_ack,
  output logic            mret_ack,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  input  logic            csr_interrupt_en,
  input  logic [XLEN-1:0] csr_mie,
  input  logic [1:0]      csr_mtvec_mode,
  input  logic [XLEN-3:0] csr_mtvec_base,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            csr_exception,
  output logic [XLEN-1:0] csr_exception_cause,
  output logic [XLEN-1:0] csr_exception_pc,
  output logic            csr_mret
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, FLUSH, COMMIT, REDIRECT} state_t;
  typedef enum logic [1:0] {KIND_EXC, KIND_IRQ, KIND_MRET} kind_t;

  state_t          state_q, state_d;
  kind_t           kind_q, kind_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] target_q, target_d;

  logic [XLEN-1:0] pend;
  logic [CW-1:0]   irq_code;
  logic            irq_hit;
  logic            irq_take;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] vec_offset;
  logic            pend_unused;

  assign pend     = irq_lines & csr_mie;
  assign irq_take = csr_interrupt_en & irq_hit;

  // Bits outside 3/7/11/16+ never raise a trap; fold them away explicitly.
  assign pend_unused = ^{pend[15:12], pend[10:8], pend[6:4], pend[2:0]};

  // Interrupt priority encode: later assignments win, so highest priority is written last.
  always_comb begin
    irq_code = '0;
    irq_hit  = 1'b0;
    for (int n = XLEN - 1; n >= 16; n--) begin
      if (pend[n]) begin
        irq_code = CW'(n);
        irq_hit  = 1'b1;
      end
    end
    if (pend[7]) begin
      irq_code = CW'(7);
      irq_hit  = 1'b1;
    end
    if (pend[3]) begin
      irq_code = CW'(3);
      irq_hit  = 1'b1;
    end
    if (pend[11]) begin
      irq_code = CW'(11);
      irq_hit  = 1'b1;
    end
  end

  // Trap vector: base, plus 4*code only for vectored-mode interrupts (wraps modulo 2^XLEN).
  assign trap_base  = {csr_mtvec_base, 2'b00};
  assign vec_offset = {cause_q[XLEN-3:0], 2'b00};

  // State register and latched trap context.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      kind_q   <= KIND_EXC;
      cause_q  <= '0;
      epc_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      target_q <= target_d;
    end
  end

  // Next-state, latch updates and state-decoded outputs.
  always_comb begin
    state_d             = state_q;
    kind_d              = kind_q;
    cause_d             = cause_q;
    epc_d               = epc_q;
    target_d            = target_q;
    flush               = 1'b0;
    trap_ack            = 1'b0;
    mret_ack            = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = '0;
    csr_exception       = 1'b0;
    csr_exception_cause = '0;
    csr_exception_pc    = '0;
    csr_mret            = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (exc_req) begin
          kind_d  = KIND_EXC;
          cause_d = XLEN'(exc_cause);
          epc_d   = exc_pc;
          state_d = FLUSH;
        end else if (irq_take) begin
          kind_d  = KIND_IRQ;
          cause_d = {1'b1, (XLEN-1)'(irq_code)};
          state_d = FLUSH;
        end else if (mret_req) begin
          kind_d  = KIND_MRET;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (flush_done) begin
          // Interrupts return to the oldest unretired instruction.
          if (kind_q == KIND_IRQ) begin
            epc_d = next_pc;
          end
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        flush = 1'b1;
        if (kind_q == KIND_MRET) begin
          csr_mret = 1'b1;
          mret_ack = 1'b1;
          target_d = csr_mepc;
        end else begin
          csr_exception       = 1'b1;
          csr_exception_cause = cause_q;
          csr_exception_pc    = epc_q;
          trap_ack            = (kind_q == KIND_EXC);
          if (kind_q == KIND_IRQ && csr_mtvec_mode == 2'd1) begin
            target_d = trap_base + vec_offset;
          end else begin
            target_d = trap_base;
          end
        end
        state_d = REDIRECT;
      end
      REDIRECT: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        if (redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed spec scenarios then randomized requests against a rule-level model.
// Latency: each transaction is followed cycle by cycle until the sequencer returns to IDLE.
// Backpressure: flush_done and redirect_ready are delayed by per-transaction cycle counts.
module tb_trap_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            nrst;
  logic            exc_req;
  logic [4:0]      exc_cause;
  logic [XLEN-1:0] exc_pc;
  logic            mret_req;
  logic [XLEN-1:0] irq_lines;
  logic [XLEN-1:0] next_pc;
  logic            flush;
  logic            flush_done;
  logic            trap_ack;
  logic            mret_ack;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;
  logic            csr_interrupt_en;
  logic [XLEN-1:0] csr_mie;
  logic [1:0]      csr_mtvec_mode;
  logic [XLEN-3:0] csr_mtvec_base;
  logic [XLEN-1:0] csr_mepc;
  logic            csr_exception;
  logic [XLEN-1:0] csr_exception_cause;
  logic [XLEN-1:0] csr_exception_pc;
  logic            csr_mret;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  typedef struct packed {
    logic [1:0]  kind;   // 0 none, 1 exception, 2 interrupt, 3 mret
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] target;
  } exp_t;

  trap_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .nrst(nrst),
    .exc_req(exc_req), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .mret_req(mret_req), .irq_lines(irq_lines), .next_pc(next_pc),
    .flush(flush), .flush_done(flush_done),
    .trap_ack(trap_ack), .mret_ack(mret_ack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .csr_interrupt_en(csr_interrupt_en), .csr_mie(csr_mie),
    .csr_mtvec_mode(csr_mtvec_mode), .csr_mtvec_base(csr_mtvec_base), .csr_mepc(csr_mepc),
    .csr_exception(csr_exception), .csr_exception_cause(csr_exception_cause),
    .csr_exception_pc(csr_exception_pc), .csr_mret(csr_mret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_output();
    return |{flush, trap_ack, mret_ack, redirect_valid, redirect_pc, csr_exception,
             csr_exception_cause, csr_exception_pc, csr_mret};
  endfunction

  // Outcome of the current request inputs, derived from the arbitration rules.
  function automatic exp_t model();
    exp_t        m;
    int          order[$];
    int          code;
    logic [31:0] pend;
    logic [31:0] base;
    m    = '0;
    code = -1;
    pend = irq_lines & csr_mie;
    base = {csr_mtvec_base, 2'b00};
    order = {11, 3, 7};
    for (int n = 16; n < 32; n++) order.push_back(n);
    if (csr_interrupt_en) begin
      foreach (order[i]) if (code < 0 && pend[order[i]]) code = order[i];
    end
    if (exc_req) begin
      m.kind = 2'd1; m.cause = {27'd0, exc_cause}; m.epc = exc_pc; m.target = base;
    end else if (code >= 0) begin
      m.kind = 2'd2; m.cause = 32'h8000_0000 | 32'(code); m.epc = next_pc;
      m.target = (csr_mtvec_mode == 2'd1) ? base + 32'(4 * code) : base;
    end else if (mret_req) begin
      m.kind = 2'd3; m.target = csr_mepc;
    end
    return m;
  endfunction

  task automatic clear_reqs();
    exc_req = 0; mret_req = 0; irq_lines = '0; flush_done = 0; redirect_ready = 0;
  endtask

  // Run one request from the current inputs to the return to IDLE, checking against the model.
  task automatic run_txn(input string nm, input int fd, input int rd, input bit drop_irq,
                         input bit pulse_exc, output logic [31:0] cause_o, output logic [31:0] rpc_o);
    exp_t        e;
    int          cyc, n_exc, n_tack, n_mack, n_mret, n_rv, fd_cnt, rd_cnt;
    logic [31:0] got_cause, got_pc, rpc;
    bit          stable, flush_ok, zero_ok, done, handshake, pulsed, idle_ok;
    e = model();
    cyc = 0; n_exc = 0; n_tack = 0; n_mack = 0; n_mret = 0; n_rv = 0;
    fd_cnt = fd; rd_cnt = rd;
    got_cause = '0; got_pc = '0; rpc = '0;
    stable = 1; flush_ok = 1; zero_ok = 1; done = 0; handshake = 0; pulsed = 0; idle_ok = 1;
    flush_done = 0; redirect_ready = 0;
    step();
    if (e.kind == 2'd0) begin
      for (int i = 0; i < 3; i++) begin
        if (any_output()) idle_ok = 0;
        step();
      end
      check({nm, "_no_trap"}, idle_ok, 1'b1);
      clear_reqs();
      cause_o = '0; rpc_o = '0;
      return;
    end
    if (drop_irq) irq_lines = '0;
    while (!done && cyc < 100) begin
      cyc++;
      if (handshake) begin
        done = 1;
        check({nm, "_idle"}, {flush, redirect_valid}, 2'b00);
        clear_reqs();
      end else begin
        if (!flush) flush_ok = 0;
        if (csr_exception) begin
          n_exc++; got_cause = csr_exception_cause; got_pc = csr_exception_pc;
        end else if (csr_exception_cause != 0 || csr_exception_pc != 0) begin
          zero_ok = 0;
        end
        if (trap_ack) begin n_tack++; exc_req = 0; end
        if (mret_ack) begin n_mack++; mret_req = 0; end
        if (csr_mret) n_mret++;
        if (redirect_valid) begin
          if (n_rv == 0) rpc = redirect_pc;
          else if (redirect_pc !== rpc) stable = 0;
          n_rv++;
          if (pulse_exc) begin
            exc_req = !pulsed;
            pulsed  = 1;
          end
          redirect_ready = (rd_cnt == 0);
          if (rd_cnt > 0) rd_cnt--;
          handshake = redirect_ready;
        end else begin
          flush_done = (fd_cnt == 0);
          if (fd_cnt > 0) fd_cnt--;
        end
        step();
      end
    end
    if (!done) clear_reqs();
    check({nm, "_done"}, done, 1'b1);
    check({nm, "_cycles"}, cyc, 4 + fd + rd);
    check({nm, "_exc_pulses"}, n_exc, (e.kind == 2'd1 || e.kind == 2'd2) ? 1 : 0);
    if (n_exc == 1) begin
      check({nm, "_cause"}, got_cause, e.cause);
      check({nm, "_epc"}, got_pc, e.epc);
    end
    check({nm, "_trap_ack"}, n_tack, (e.kind == 2'd1) ? 1 : 0);
    check({nm, "_mret_ack"}, n_mack, (e.kind == 2'd3) ? 1 : 0);
    check({nm, "_csr_mret"}, n_mret, (e.kind == 2'd3) ? 1 : 0);
    check({nm, "_redirect_pc"}, rpc, e.target);
    check({nm, "_rpc_stable"}, stable, 1'b1);
    check({nm, "_flush_held"}, flush_ok, 1'b1);
    check({nm, "_cause_pc_zero"}, zero_ok, 1'b1);
    cause_o = got_cause;
    rpc_o   = rpc;
  endtask

  initial begin
    logic [31:0] c, r;
    nrst = 0;
    clear_reqs();
    exc_cause = '0; exc_pc = '0; next_pc = '0;
    csr_interrupt_en = 0; csr_mie = '0; csr_mtvec_mode = 2'd0; csr_mtvec_base = '0; csr_mepc = '0;
    #1;
    check("reset_outputs", any_output(), 1'b0);
    step(); step();
    nrst = 1;
    step();
    check("post_reset_idle", any_output(), 1'b0);

    // Direct-mode exception.
    csr_mtvec_base = 30'h2000; csr_mtvec_mode = 2'd0;
    exc_req = 1; exc_cause = 5'd2; exc_pc = 32'h104;
    run_txn("dir_exc", 0, 0, 0, 0, c, r);
    check("dir_exc_cause_const", c, 32'h2);
    check("dir_exc_rpc_const", r, 32'h8000);

    // Vectored timer interrupt with a slow drain.
    csr_mtvec_mode = 2'd1; csr_interrupt_en = 1; csr_mie = 32'h80; irq_lines = 32'h80; next_pc = 32'h200;
    run_txn("vec_irq", 3, 0, 0, 0, c, r);
    check("vec_irq_cause_const", c, 32'h8000_0007);
    check("vec_irq_rpc_const", r, 32'h801C);

    // Global MIE off masks everything, then MEI wins over MSI/MTI.
    csr_interrupt_en = 0; csr_mie = '1; irq_lines = 32'h888;
    run_txn("masked", 0, 0, 0, 0, c, r);
    csr_interrupt_en = 1; irq_lines = 32'h888;
    run_txn("prio", 1, 1, 1, 0, c, r);
    check("prio_cause_const", c, 32'h8000_000B);

    // Exception beats a simultaneous takeable interrupt.
    irq_lines = 32'h888; exc_req = 1; exc_cause = 5'd5; exc_pc = 32'h300;
    run_txn("exc_vs_irq", 0, 0, 0, 0, c, r);
    check("exc_vs_irq_cause_const", c, 32'h5);

    // mret returns to mepc.
    csr_mepc = 32'h400; mret_req = 1;
    run_txn("mret", 0, 0, 0, 0, c, r);
    check("mret_rpc_const", r, 32'h400);

    // Redirect stalled 5 cycles with an exception pulse that must be ignored.
    mret_req = 1;
    run_txn("stall", 0, 5, 0, 1, c, r);
    step();
    check("stall_pulse_ignored", flush, 1'b0);

    // Reset in the middle of FLUSH aborts without a CSR commit.
    exc_req = 1; exc_cause = 5'd4; exc_pc = 32'h500;
    step();
    check("abort_in_flush", flush, 1'b1);
    nrst = 0;
    #1;
    check("abort_outputs_zero", any_output(), 1'b0);
    exc_req = 0;
    step();
    check("abort_no_commit", csr_exception, 1'b0);
    nrst = 1;
    step();
    check("abort_idle_after", any_output(), 1'b0);

    // Randomized requests.
    for (int t = 0; t < 40; t++) begin
      csr_mtvec_base   = 30'($urandom);
      csr_mtvec_mode   = 2'($urandom_range(0, 3));
      csr_interrupt_en = 1'($urandom_range(0, 1));
      csr_mie          = $urandom;
      irq_lines        = $urandom & $urandom & $urandom;
      next_pc          = $urandom;
      csr_mepc         = $urandom;
      exc_req          = ($urandom_range(0, 3) == 0);
      exc_cause        = 5'($urandom);
      exc_pc           = $urandom;
      mret_req         = ($urandom_range(0, 2) == 0);
      run_txn($sformatf("rnd%0d", t), $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 0, c, r);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
